// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// Mode 0: SCLK idles low, data sampled on rise, shifted on fall.
package spi_pkg;

  typedef logic [7:0] byte_t;

  localparam logic  SPI_CPOL      = 1'b0;
  localparam logic  SPI_CPHA      = 1'b0;
  localparam byte_t IDLE_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one SPI pin with edge detect.
// Edges compare the synchronized level with its previous sample.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // shift the pin through the sync chain, keep the last level
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target: oversampled pins, rx byte stream,
// one-entry tx buffer shifted out MSB first on MISO.
module spi_responder
  import spi_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter byte_t IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_en,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic       i_clear_flags,
  output logic       o_overrun,
  output logic       o_underrun
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0] r_state;
  logic [2:0] r_bit_cnt;
  byte_t      r_rx_shift;
  byte_t      r_tx_shift;
  byte_t      r_buf;
  logic       r_buf_full;
  byte_t      r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;
  logic       r_underrun;
  logic       r_miso;
  logic       r_miso_en;

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .i_clock(i_clock), .i_reset(i_reset), .i_pin(i_spi_clk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise),
    .o_fall(w_sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_clock(i_clock), .i_reset(i_reset), .i_pin(i_spi_cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_rise),
    .o_fall(w_cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .i_clock(i_clock), .i_reset(i_reset), .i_pin(i_spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise),
    .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sclk_level, w_cs_level,
                      w_mosi_rise, w_mosi_fall};

  logic  w_start, w_stop, w_act;
  logic  w_bit_in, w_bit_out, w_load, w_write;
  logic  w_rx_done, w_rx_block;
  byte_t w_load_byte, w_rx_byte;

  assign w_start     = (r_state == ST_IDLE) && w_cs_fall;
  assign w_stop      = (r_state == ST_ACTIVE) && w_cs_rise;
  assign w_act       = (r_state == ST_ACTIVE) && !w_cs_rise;
  assign w_bit_in    = w_act && w_sclk_rise;
  assign w_bit_out   = w_act && w_sclk_fall;
  assign w_load      = w_start ||
                       (w_bit_out && (r_bit_cnt == 3'd0));
  assign w_load_byte = r_buf_full ? r_buf : IDLE_BYTE;
  assign w_write     = i_tx_valid && !r_buf_full;
  assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};
  assign w_rx_done   = w_bit_in && (r_bit_cnt == 3'd7);
  assign w_rx_block  = r_rx_valid && !i_rx_ready;

  // select state, bit counter and receive shifter
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= '0;
    end else if (w_start) begin
      r_state    <= ST_ACTIVE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= '0;
    end else if (w_stop) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= '0;
    end else if (w_bit_in) begin
      r_rx_shift <= w_rx_byte;
      r_bit_cnt  <= r_bit_cnt + 3'd1;
    end
  end

  // transmit shifter and registered MISO pin
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_shift <= '0;
      r_miso     <= 1'b1;
      r_miso_en  <= 1'b0;
    end else if (w_stop) begin
      r_miso     <= 1'b1;
      r_miso_en  <= 1'b0;
    end else if (w_load) begin
      r_tx_shift <= w_load_byte;
      r_miso     <= w_load_byte[7];
      r_miso_en  <= 1'b1;
    end else if (w_bit_out) begin
      r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      r_miso     <= r_tx_shift[6];
    end
  end

  // one-entry transmit buffer; a write only lands when empty
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (w_write) begin
      r_buf      <= i_tx_data;
      r_buf_full <= 1'b1;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end
  end

  // received byte holding register with valid/ready
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_done && !w_rx_block) begin
      r_rx_data  <= w_rx_byte;
      r_rx_valid <= 1'b1;
    end else if (i_rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  // sticky error flags; a new event beats a clear
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (i_clear_flags) begin
        r_overrun  <= 1'b0;
        r_underrun <= 1'b0;
      end
      if (w_rx_done && w_rx_block)
        r_overrun  <= 1'b1;
      if (w_load && !r_buf_full)
        r_underrun <= 1'b1;
    end
  end

  assign o_spi_miso    = r_miso;
  assign o_spi_miso_en = r_miso_en;
  assign o_tx_ready    = !r_buf_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_overrun     = r_overrun;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a bit-banged mode-0 master at clock/16
// against a byte-level model of what each side should see.
module tb_spi_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_en;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       clear_flags = 1'b0;
  logic       overrun, underrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];

  spi_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .i_clock(clock), .i_reset(reset),
    .i_spi_clk(spi_clk), .i_spi_cs_n(spi_cs_n),
    .i_spi_mosi(spi_mosi), .o_spi_miso(spi_miso),
    .o_spi_miso_en(spi_miso_en),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .i_rx_ready(rx_ready), .i_clear_flags(clear_flags),
    .o_overrun(overrun), .o_underrun(underrun)
  );

  always #5 clock = ~clock;

  // consumer side: every accepted rx byte
  always @(posedge clock)
    if (!reset && rx_valid && rx_ready) rx_q.push_back(rx_data);

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset;
    reset = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0;
    spi_mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    rx_ready = 1'b1; clear_flags = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int k = 0;
    while (!tx_ready && k < 200) begin tick(1); k++; end
    n_tests++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_wait tx_ready=%b required 1", tx_ready);
    end
    tx_data = b; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // nbits of mo, MSB first; optional mid-byte tx push and a
  // one-cycle rx pop aligned with the last rise being acted on
  task automatic xfer(input logic [7:0] mo, input int nbits,
                      input bit push_en, input logic [7:0] pb,
                      input bit pop_last,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      if (push_en && i == 3) begin
        tick(2);
        tx_data = pb; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(5);
      end else begin
        tick(8);
      end
      mi[i] = spi_miso;
      spi_clk = 1'b1;
      if (pop_last && i == 0) begin
        tick(2);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(5);
      end else begin
        tick(8);
      end
      spi_clk = 1'b0;
    end
    tick(8);
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if (spi_miso !== 1'b1) begin n_fail++;
      $display("FAIL reset_miso got %b want 1", spi_miso); end
    n_tests++;
    if (spi_miso_en !== 1'b0) begin n_fail++;
      $display("FAIL reset_miso_en got %b want 0", spi_miso_en); end
    n_tests++;
    if (tx_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    n_tests++;
    if (rx_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_tests++;
    if (rx_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_tests++;
    if (overrun !== 1'b0 || underrun !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags got %b%b want 00",
               overrun, underrun); end
  endtask

  task automatic test_basic;
    logic [7:0] mi;
    do_reset();
    rx_q.delete();
    push_tx(8'hA5);
    spi_cs_n = 1'b0;
    xfer(8'h3C, 8, 1'b1, 8'h5E, 1'b0, mi);
    n_tests++;
    if (mi !== 8'hA5) begin n_fail++;
      $display("FAIL basic_miso got %h want a5", mi); end
    n_tests++;
    if (spi_miso_en !== 1'b1) begin n_fail++;
      $display("FAIL basic_en got %b want 1", spi_miso_en); end
    spi_cs_n = 1'b1;
    tick(8);
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin n_fail++;
      $display("FAIL basic_rx got n=%0d %h want 3c",
               rx_q.size(), rx_data); end
    n_tests++;
    if (tx_ready !== 1'b1) begin n_fail++;
      $display("FAIL basic_tx_ready got %b want 1", tx_ready); end
    n_tests++;
    if (overrun !== 1'b0 || underrun !== 1'b0) begin n_fail++;
      $display("FAIL basic_flags got %b%b want 00",
               overrun, underrun); end
    n_tests++;
    if (spi_miso_en !== 1'b0 || spi_miso !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_deselect en=%b miso=%b want 0/1",
               spi_miso_en, spi_miso); end
  endtask

  task automatic test_multi;
    logic [7:0] mi [3];
    logic [7:0] want_mi [3];
    bit bad;
    want_mi = '{8'h10, 8'hFF, 8'hFF};
    do_reset();
    rx_q.delete();
    push_tx(8'h10);
    spi_cs_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] m;
      xfer(8'(k + 1), 8, 1'b0, 8'h00, 1'b0, m);
      mi[k] = m;
    end
    spi_cs_n = 1'b1;
    tick(8);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (mi[k] !== want_mi[k]) begin n_fail++;
        $display("FAIL multi_miso%0d got %h want %h",
                 k, mi[k], want_mi[k]); end
    end
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++;
      $display("FAIL multi_underrun got %b want 1", underrun); end
    bad = (rx_q.size() != 3);
    if (!bad)
      for (int k = 0; k < 3; k++)
        if (rx_q[k] !== 8'(k + 1)) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++;
      $display("FAIL multi_rx got n=%0d want 01 02 03",
               rx_q.size()); end
  endtask

  task automatic test_overrun;
    logic [7:0] mi;
    do_reset();
    rx_ready = 1'b0;
    spi_cs_n = 1'b0;
    xfer(8'h11, 8, 1'b0, 8'h00, 1'b0, mi);
    xfer(8'h22, 8, 1'b0, 8'h00, 1'b0, mi);
    spi_cs_n = 1'b1;
    tick(8);
    n_tests++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin n_fail++;
      $display("FAIL ovr_hold got %h v=%b want 11 v=1",
               rx_data, rx_valid); end
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++;
      $display("FAIL ovr_flag got %b want 1", overrun); end
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++;
      $display("FAIL ovr_clear got %b want 0", overrun); end
    rx_ready = 1'b1;
    tick(2);
  endtask

  task automatic test_partial;
    logic [7:0] mi;
    do_reset();
    rx_q.delete();
    spi_cs_n = 1'b0;
    xfer(8'hB7, 5, 1'b0, 8'h00, 1'b0, mi);
    spi_cs_n = 1'b1;
    tick(4);
    n_tests++;
    if (spi_miso_en !== 1'b0 || spi_miso !== 1'b1) begin
      n_fail++;
      $display("FAIL part_deselect en=%b miso=%b want 0/1",
               spi_miso_en, spi_miso); end
    tick(8);
    n_tests++;
    if (rx_q.size() != 0 || rx_valid !== 1'b0) begin n_fail++;
      $display("FAIL part_no_rx got n=%0d v=%b want 0",
               rx_q.size(), rx_valid); end
    spi_cs_n = 1'b0;
    xfer(8'hC3, 8, 1'b0, 8'h00, 1'b0, mi);
    spi_cs_n = 1'b1;
    tick(8);
    n_tests++;
    if (rx_q.size() != 1 || rx_data !== 8'hC3) begin n_fail++;
      $display("FAIL part_full got n=%0d %h want c3",
               rx_q.size(), rx_data); end
  endtask

  task automatic test_pop_coincident;
    logic [7:0] mi;
    do_reset();
    rx_q.delete();
    rx_ready = 1'b0;
    spi_cs_n = 1'b0;
    xfer(8'hA1, 8, 1'b0, 8'h00, 1'b0, mi);
    xfer(8'hB2, 8, 1'b0, 8'h00, 1'b1, mi);
    spi_cs_n = 1'b1;
    tick(4);
    n_tests++;
    if (rx_data !== 8'hB2 || rx_valid !== 1'b1) begin n_fail++;
      $display("FAIL pop_new got %h v=%b want b2 v=1",
               rx_data, rx_valid); end
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++;
      $display("FAIL pop_overrun got %b want 0", overrun); end
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA1) begin n_fail++;
      $display("FAIL pop_old got n=%0d want a1", rx_q.size()); end
    rx_ready = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid;
    logic [7:0] mi;
    do_reset();
    push_tx(8'h66);
    spi_cs_n = 1'b0;
    xfer(8'h9C, 8, 1'b0, 8'h00, 1'b0, mi);
    xfer(8'hF0, 4, 1'b0, 8'h00, 1'b0, mi);
    push_tx(8'h44);
    reset = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0;
    tick(1);
    n_tests++;
    if (spi_miso !== 1'b1 || spi_miso_en !== 1'b0 ||
        tx_ready !== 1'b1 || rx_valid !== 1'b0 ||
        rx_data !== 8'h00 || overrun !== 1'b0 ||
        underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got m%b e%b r%b v%b d%h o%b u%b",
               spi_miso, spi_miso_en, tx_ready, rx_valid,
               rx_data, overrun, underrun);
    end
    reset = 1'b0;
    tick(4);
    rx_q.delete();
    push_tx(8'h77);
    spi_cs_n = 1'b0;
    xfer(8'h5A, 8, 1'b1, 8'h12, 1'b0, mi);
    spi_cs_n = 1'b1;
    tick(8);
    n_tests++;
    if (rx_q.size() != 1 || rx_data !== 8'h5A) begin n_fail++;
      $display("FAIL mid_after_rx got n=%0d %h want 5a",
               rx_q.size(), rx_data); end
    n_tests++;
    if (mi !== 8'h77) begin n_fail++;
      $display("FAIL mid_after_miso got %h want 77", mi); end
  endtask

  // random bytes and random buffer fills against a byte model
  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      logic [7:0] mo_q[$];
      logic [7:0] want_next;
      bit         want_und;
      bit         bad;
      logic [7:0] mi, mo, pb;
      bit         pe;
      do_reset();
      rx_q.delete();
      want_next = 8'hFF;
      want_und  = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        want_next = 8'($urandom);
        want_und  = 1'b0;
        push_tx(want_next);
      end
      spi_cs_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
        mo = 8'($urandom);
        pb = 8'($urandom);
        pe = ($urandom_range(0, 1) == 1);
        mo_q.push_back(mo);
        xfer(mo, 8, pe, pb, 1'b0, mi);
        n_tests++;
        if (mi !== want_next) begin n_fail++;
          $display("FAIL rand_miso r%0d b%0d got %h want %h",
                   r, k, mi, want_next); end
        want_next = pe ? pb : 8'hFF;
        if (!pe) want_und = 1'b1;
      end
      spi_cs_n = 1'b1;
      tick(8);
      n_tests++;
      if (underrun !== want_und) begin n_fail++;
        $display("FAIL rand_underrun r%0d got %b want %b",
                 r, underrun, want_und); end
      bad = (rx_q.size() != mo_q.size());
      if (!bad)
        for (int k = 0; k < mo_q.size(); k++)
          if (rx_q[k] !== mo_q[k]) bad = 1'b1;
      n_tests++;
      if (bad) begin n_fail++;
        $display("FAIL rand_rx r%0d got n=%0d want n=%0d",
                 r, rx_q.size(), mo_q.size()); end
      n_tests++;
      if (tx_ready !== 1'b1 || overrun !== 1'b0) begin n_fail++;
        $display("FAIL rand_state r%0d rdy=%b ovr=%b want 1/0",
                 r, tx_ready, overrun); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_overrun();
    test_partial();
    test_pop_coincident();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
